// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared cell operation encoding and the single-bit cell function
//               used by the systolic array cells.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    typedef enum logic [1:0] {
        OP_NOR = 2'd0,
        OP_AND = 2'd1,
        OP_OR  = 2'd2,
        OP_XOR = 2'd3
    } op_t;

    function automatic logic cell_op(input op_t op, input logic a, input logic b);
        logic res;
        case (op)
            OP_NOR:  res = ~(a | b);
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            default: res = a ^ b;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_cell.sv
`default_nettype none
// ============================================================================
// Module      : systolic_cell
// Description : One array cell: applies the cell op to its left/up operands and
//               registers the result when the array advances.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_cell
    import systolic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_op,
    input  logic       i_left,
    input  logic       i_up,
    output logic       o_q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_q <= 1'b0;
        end else if (i_en) begin
            o_q <= cell_op(op_t'(i_op), i_left, i_up);
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pipe
// Description : Pipelined ROW x COLUMN systolic logic array with valid/ready
//               streaming; one token per cycle, latency ROW+COLUMN-1.
//               Optional runtime cell-op select: SYSTOLIC_OP_SELECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_pipe
    import systolic_pkg::*;
#(
    parameter int ROW    = 4,
    parameter int COLUMN = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ROW-1:0]    in_row,
    input  logic [COLUMN-1:0] in_col,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out
`ifdef SYSTOLIC_OP_SELECT_EN
    ,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_op
`endif
);

    localparam int LAT    = ROW + COLUMN - 1;
    localparam int c_occW = $clog2(LAT + 1);
    localparam logic [c_occW-1:0] c_occOne = c_occW'(1);
    localparam logic [c_occW-1:0] c_occMax = c_occW'(LAT);

    logic                  w_advance;
    logic                  w_accept;
    logic                  w_outHs;
    logic [1:0]            w_opBits;
    logic [ROW-1:0]        w_rowIn;
    logic [COLUMN-1:0]     w_colIn;
    logic [ROW*COLUMN-1:0] w_cellQ;
    logic [LAT-1:0]        r_vld;
    logic [c_occW-1:0]     r_occ;

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;
    assign w_accept  = in_valid && w_advance;
    assign w_outHs   = out_valid && out_ready;

    // Row i is delayed i stages so it meets the token's diagonal wavefront.
    for (genvar r = 0; r < ROW; r++) begin : g_rowSkew
        if (r == 0) begin : g_direct
            assign w_rowIn[r] = in_row[r];
        end else if (r == 1) begin : g_single
            logic r_sr;
            always_ff @(posedge clk) begin
                if (!rst_n)         r_sr <= 1'b0;
                else if (w_advance) r_sr <= in_row[r];
            end
            assign w_rowIn[r] = r_sr;
        end else begin : g_chain
            logic [r-1:0] r_sr;
            always_ff @(posedge clk) begin
                if (!rst_n)         r_sr <= '0;
                else if (w_advance) r_sr <= {r_sr[r-2:0], in_row[r]};
            end
            assign w_rowIn[r] = r_sr[r-1];
        end
    end

    for (genvar c = 0; c < COLUMN; c++) begin : g_colSkew
        if (c == 0) begin : g_direct
            assign w_colIn[c] = in_col[c];
        end else if (c == 1) begin : g_single
            logic r_sr;
            always_ff @(posedge clk) begin
                if (!rst_n)         r_sr <= 1'b0;
                else if (w_advance) r_sr <= in_col[c];
            end
            assign w_colIn[c] = r_sr;
        end else begin : g_chain
            logic [c-1:0] r_sr;
            always_ff @(posedge clk) begin
                if (!rst_n)         r_sr <= '0;
                else if (w_advance) r_sr <= {r_sr[c-2:0], in_col[c]};
            end
            assign w_colIn[c] = r_sr[c-1];
        end
    end

    for (genvar r = 0; r < ROW; r++) begin : g_cellRow
        for (genvar c = 0; c < COLUMN; c++) begin : g_cellCol
            localparam int c_idx = r * COLUMN + c;
            logic w_left;
            logic w_up;
            if (c == 0) begin : g_leftEdge
                assign w_left = w_rowIn[r];
            end else begin : g_leftNbr
                assign w_left = w_cellQ[c_idx-1];
            end
            if (r == 0) begin : g_upEdge
                assign w_up = w_colIn[c];
            end else begin : g_upNbr
                assign w_up = w_cellQ[c_idx-COLUMN];
            end
            systolic_cell u_cell (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_en   (w_advance),
                .i_op   (w_opBits),
                .i_left (w_left),
                .i_up   (w_up),
                .o_q    (w_cellQ[c_idx])
            );
        end
    end

    if (LAT == 1) begin : g_vldSingle
        always_ff @(posedge clk) begin
            if (!rst_n)         r_vld <= '0;
            else if (w_advance) r_vld <= w_accept;
        end
    end else begin : g_vldChain
        always_ff @(posedge clk) begin
            if (!rst_n)         r_vld <= '0;
            else if (w_advance) r_vld <= {r_vld[LAT-2:0], w_accept};
        end
    end

    assign out_valid = r_vld[LAT-1];
    assign out       = r_vld[LAT-1] & w_cellQ[ROW*COLUMN-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (w_accept && !w_outHs) begin
            r_occ <= r_occ + c_occOne;
        end else if (w_outHs && !w_accept) begin
            r_occ <= r_occ - c_occOne;
        end
    end

    a_occBound: assert property (@(posedge clk) disable iff (!rst_n) (r_occ <= c_occMax));

`ifdef SYSTOLIC_OP_SELECT_EN
    // Op only changes on an empty array so no token ever mixes two ops.
    op_t r_op;
    assign cfg_ready = (r_occ == '0) && !w_accept;
    always_ff @(posedge clk) begin
        if (!rst_n)                      r_op <= OP_NOR;
        else if (cfg_valid && cfg_ready) r_op <= op_t'(cfg_op);
    end
    assign w_opBits = r_op;
`else
    assign w_opBits = OP_NOR;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_pipe
// Description : Directed self-checking bench for systolic_pipe (ROW=4, COLUMN=10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_pipe;
    import systolic_pkg::*;

    localparam int ROW    = 4;
    localparam int COLUMN = 10;
    localparam int LAT    = ROW + COLUMN - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [ROW-1:0]    in_row;
    logic [COLUMN-1:0] in_col;
    logic              out_valid;
    logic              out_ready;
    logic              out;
`ifdef SYSTOLIC_OP_SELECT_EN
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_op;
    bit                cfgTake;
    bit                cfgDone;
`endif

    int  total = 0;
    int  bad   = 0;
    bit  expQ[$];
    op_t tbOp = OP_NOR;
    bit  useHand = 1'b0;
    bit  handExp = 1'b0;
    bit  prevStall = 1'b0;
    bit  prevOut = 1'b0;
    int  emitted = 0;
    int  accepted = 0;
    int  n;

    logic [ROW-1:0]    hRow [4] = '{4'h0, 4'hF, 4'h0, 4'hF};
    logic [COLUMN-1:0] hCol [4] = '{10'h000, 10'h3FF, 10'h3FF, 10'h000};
    bit                hExp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    systolic_pipe #(.ROW(ROW), .COLUMN(COLUMN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .in_col    (in_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
`ifdef SYSTOLIC_OP_SELECT_EN
        ,
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_op    (cfg_op)
`endif
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference: the original combinational array evaluated for one token.
    function automatic bit model(input logic [ROW-1:0] r, input logic [COLUMN-1:0] c, input op_t op);
        bit w [0:ROW][0:COLUMN];
        w[0][0] = 1'b0;
        for (int i = 1; i <= ROW; i++)    w[i][0] = r[i-1];
        for (int j = 1; j <= COLUMN; j++) w[0][j] = c[j-1];
        for (int i = 1; i <= ROW; i++)
            for (int j = 1; j <= COLUMN; j++)
                w[i][j] = cell_op(op, w[i][j-1], w[i-1][j]);
        return w[ROW][COLUMN];
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One cycle: settle, check handshake-side outputs, score, then clock.
    task automatic tick();
        bit acc;
        int occ;
        #1;
        occ = expQ.size();
        acc = in_valid && (!out_valid || out_ready);
        check("in_ready", in_ready, !out_valid || out_ready);
        if (!out_valid) check("out_zero_when_idle", out, 1'b0);
        if (prevStall) begin
            check("stall_hold_valid", out_valid, 1'b1);
            check("stall_hold_out", out, prevOut);
        end
        if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                check("unexpected_result", out_valid, 1'b0);
            end else begin
                check("result", out, expQ.pop_front());
                emitted++;
            end
        end
`ifdef SYSTOLIC_OP_SELECT_EN
        check("cfg_ready", cfg_ready, (occ == 0) && !acc);
        cfgTake = cfg_valid && (occ == 0) && !acc;
`endif
        if (acc) begin
            expQ.push_back(useHand ? handExp : model(in_row, in_col, tbOp));
            accepted++;
        end
        prevStall = out_valid && !out_ready;
        prevOut   = out;
        @(posedge clk);
        #1;
`ifdef SYSTOLIC_OP_SELECT_EN
        if (cfgTake) begin
            tbOp    = op_t'(cfg_op);
            cfgDone = 1'b1;
        end
`endif
    endtask

    task automatic drain(output int cnt);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        while (expQ.size() != 0 && cnt < 100) begin
            tick();
            cnt++;
        end
        checkInt("drain_empty", expQ.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_row = '0; in_col = '0;
`ifdef SYSTOLIC_OP_SELECT_EN
        cfg_valid = 1'b0; cfg_op = 2'd0; cfgTake = 1'b0; cfgDone = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out", out, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        // Single all-zero NOR token: result 1, visible exactly LAT cycles on.
        out_ready = 1'b1; in_valid = 1'b1; in_row = '0; in_col = '0;
        useHand = 1'b1; handExp = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            #1;
            check("latency_early", out_valid, 1'b0);
            tick();
        end
        #1;
        check("latency_valid", out_valid, 1'b1);
        check("latency_out", out, 1'b1);
        drain(n);

        // Hand-computed NOR vectors back to back.
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_row = hRow[k]; in_col = hCol[k]; handExp = hExp[k];
            tick();
        end
        drain(n);
        useHand = 1'b0;

        // 200-token back-to-back stream.
        emitted = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            in_row = ROW'($urandom); in_col = COLUMN'($urandom);
            tick();
        end
        drain(n);
        checkInt("stream_count", emitted, 200);
        checkInt("stream_tail_cycles", n, LAT);

        // Continuous input against a randomly stalling sink.
        emitted = 0; accepted = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 150; k++) begin
            in_row = ROW'($urandom); in_col = COLUMN'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain(n);
        checkInt("stall_no_loss", emitted, accepted);

        // Reset with 7 tokens in flight, first one already at the output.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_row = ROW'($urandom); in_col = COLUMN'($urandom);
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_out", out, 1'b0);
        rst_n = 1'b1;
        expQ.delete();
        prevStall = 1'b0;
        repeat (20) tick();

`ifdef SYSTOLIC_OP_SELECT_EN
        // Op change requested with 3 tokens in flight waits for the drain.
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_row = ROW'($urandom); in_col = COLUMN'($urandom);
            tick();
        end
        in_valid = 1'b0; cfg_valid = 1'b1; cfg_op = OP_AND; cfgDone = 1'b0;
        n = 0;
        while (!cfgDone && n < 40) begin
            tick();
            n++;
        end
        cfg_valid = 1'b0;
        checkInt("cfg_and_wait", n, LAT + 1);
        useHand = 1'b1; in_valid = 1'b1;
        in_row = '1; in_col = '1;      handExp = 1'b1; tick();
        in_row = '1; in_col = 10'h3DF; handExp = 1'b0; tick();
        drain(n);

        cfg_valid = 1'b1; cfg_op = OP_OR; cfgDone = 1'b0;
        tick();
        cfg_valid = 1'b0;
        in_valid = 1'b1;
        in_row = 4'b0000; in_col = '0; handExp = 1'b0; tick();
        in_row = 4'b0100; in_col = '0; handExp = 1'b1; tick();
        drain(n);
        useHand = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
